coin_credit_ctrl: RTL and testbench



---
 rtl/coin_credit_ctrl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_coin_credit_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_credit_ctrl.sv
// coin_credit_ctrl
// ----------------
// Consumer end of the coin-inserter handshake. Each coin arrives as an
// in_rdy / in_data / in_cmp strobe sequence on three consecutive cycles.
// Accepted coins are added to the running credit. When the credit reaches
// the loaded fare, a one-cycle ticket pulse is issued. Any remainder is then
// paid out as change, one one-hot coin per cycle, largest coin first.
//
// Optional feature macro: REFUND_CANCEL_EN
//   When defined, a cancel input exists. Asserting cancel in IDLE with
//   non-zero credit refunds the whole credit as change, and no ticket is
//   issued.
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   rst        in   synchronous, active-high reset
//   fare       in   [7:0] ticket price, latched by fare_load in IDLE at zero credit
//   fare_load  in   fare load strobe
//   in_rdy     in   coin-transfer start strobe
//   in_data    in   [7:0] coin value, valid the cycle after in_rdy
//   in_cmp     in   transfer-complete strobe, two cycles after in_rdy
//   cancel     in   refund request (REFUND_CANCEL_EN only)
//   credit     out  [7:0] current accumulated credit
//   ticket     out  one-cycle ticket-issue pulse
//   chg_coin   out  [3:0] one-hot change coin: 0001=1, 0010=2, 0100=5, 1000=10
//   chg_vld    out  chg_coin valid
//   busy       out  high whenever the controller is not in IDLE
//   err        out  one-cycle pulse on a rejected coin or a protocol violation
//
// Parameter
//   MAX_CREDIT  credit ceiling. A coin that would exceed it is refunded.

module coin_credit_ctrl #(
    parameter logic [7:0] MAX_CREDIT = 8'd99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] fare,
    input  logic       fare_load,
    input  logic       in_rdy,
    input  logic [7:0] in_data,
    input  logic       in_cmp,
`ifdef REFUND_CANCEL_EN
    input  logic       cancel,
`endif
    output logic [7:0] credit,
    output logic       ticket,
    output logic [3:0] chg_coin,
    output logic       chg_vld,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_WAIT_CMP  = 3'd2,
        ST_ADD       = 3'd3,
        ST_ISSUE     = 3'd4,
        ST_CHANGE    = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] credit_q, credit_d;
    logic [7:0] fare_q, fare_d;
    logic [7:0] coin_q, coin_d;
    logic [7:0] rem_q, rem_d;
    logic       ticket_q, ticket_d;
    logic [3:0] chg_coin_q, chg_coin_d;
    logic       chg_vld_q, chg_vld_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;
    logic [8:0] sum_s;
    logic [7:0] issue_rem_s;
    logic       cancel_s;

`ifdef REFUND_CANCEL_EN
    assign cancel_s = cancel;
`else
    assign cancel_s = 1'b0;
`endif

    // Largest change coin that does not exceed the remainder (10, 5, 2, 1).
    function automatic logic [3:0] greedy_code(input logic [7:0] rem);
        logic [3:0] code;
        if (rem >= 8'd10) begin
            code = 4'b1000;
        end else if (rem >= 8'd5) begin
            code = 4'b0100;
        end else if (rem >= 8'd2) begin
            code = 4'b0010;
        end else if (rem >= 8'd1) begin
            code = 4'b0001;
        end else begin
            code = 4'b0000;
        end
        return code;
    endfunction

    // Face value of a one-hot change coin.
    function automatic logic [7:0] code_value(input logic [3:0] code);
        logic [7:0] val;
        case (code)
            4'b1000: val = 8'd10;
            4'b0100: val = 8'd5;
            4'b0010: val = 8'd2;
            4'b0001: val = 8'd1;
            default: val = 8'd0;
        endcase
        return val;
    endfunction

    // True only for the coin denominations the machine accepts.
    function automatic logic coin_legal(input logic [7:0] v);
        logic ok;
        case (v)
            8'd1, 8'd2, 8'd5, 8'd10: ok = 1'b1;
            default:                 ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        credit_d    = credit_q;
        fare_d      = fare_q;
        coin_d      = coin_q;
        rem_d       = rem_q;
        ticket_d    = 1'b0;
        chg_coin_d  = 4'b0000;
        chg_vld_d   = 1'b0;
        err_d       = 1'b0;
        // The 9-bit sum lets the ceiling check see a carry without wrapping credit.
        sum_s       = {1'b0, credit_q} + {1'b0, coin_q};
        issue_rem_s = credit_q - fare_q;

        // A new transfer may only start in IDLE. Elsewhere it is flagged and dropped.
        if (in_rdy && (state_q != ST_IDLE)) begin
            err_d = 1'b1;
        end else begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                // Cancel takes precedence over a transfer that starts in the same cycle.
                if (cancel_s) begin
                    if (in_rdy) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = 1'b0;
                    end
                    if (credit_q != 8'd0) begin
                        rem_d    = credit_q;
                        credit_d = 8'd0;
                        state_d  = ST_CHANGE;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end else if (in_rdy) begin
                    state_d = ST_WAIT_DATA;
                end else if (fare_load && (credit_q == 8'd0)) begin
                    fare_d = fare;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DATA: begin
                coin_d  = in_data;
                state_d = ST_WAIT_CMP;
            end
            ST_WAIT_CMP: begin
                if (in_cmp) begin
                    state_d = ST_ADD;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ADD: begin
                if (!coin_legal(coin_q)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (sum_s > {1'b0, MAX_CREDIT}) begin
                    // The rejected coin is handed back through the change path.
                    err_d   = 1'b1;
                    rem_d   = coin_q;
                    state_d = ST_CHANGE;
                end else begin
                    credit_d = sum_s[7:0];
                    // A zero fare means accumulate only, so no ticket is ever issued.
                    if ((fare_q != 8'd0) && (sum_s[7:0] >= fare_q)) begin
                        ticket_d = 1'b1;
                        state_d  = ST_ISSUE;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            ST_ISSUE: begin
                credit_d = 8'd0;
                // The first change coin goes out here so it is visible the cycle after ticket.
                if (issue_rem_s != 8'd0) begin
                    chg_coin_d = greedy_code(issue_rem_s);
                    chg_vld_d  = 1'b1;
                    rem_d      = issue_rem_s - code_value(greedy_code(issue_rem_s));
                    state_d    = ST_CHANGE;
                end else begin
                    rem_d      = 8'd0;
                    state_d    = ST_IDLE;
                end
            end
            ST_CHANGE: begin
                if (rem_q != 8'd0) begin
                    chg_coin_d = greedy_code(rem_q);
                    chg_vld_d  = 1'b1;
                    rem_d      = rem_q - code_value(greedy_code(rem_q));
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            credit_q   <= 8'd0;
            fare_q     <= 8'd0;
            coin_q     <= 8'd0;
            rem_q      <= 8'd0;
            ticket_q   <= 1'b0;
            chg_coin_q <= 4'b0000;
            chg_vld_q  <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            fare_q     <= fare_d;
            coin_q     <= coin_d;
            rem_q      <= rem_d;
            ticket_q   <= ticket_d;
            chg_coin_q <= chg_coin_d;
            chg_vld_q  <= chg_vld_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign credit   = credit_q;
    assign ticket   = ticket_q;
    assign chg_coin = chg_coin_q;
    assign chg_vld  = chg_vld_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_coin_credit_ctrl.sv
// Testbench for coin_credit_ctrl (credit ceiling set to 20).
// The stimulus pushes the expected ticket, change and err events into a queue.
// Each event carries its expected edge number. A negedge monitor pops and
// compares every event the DUT presents. The cancel scenario runs only when
// REFUND_CANCEL_EN is defined.

module tb_coin_credit_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] fare;
    logic       fare_load;
    logic       in_rdy;
    logic [7:0] in_data;
    logic       in_cmp;
`ifdef REFUND_CANCEL_EN
    logic       cancel;
`endif
    logic [7:0] credit;
    logic       ticket;
    logic [3:0] chg_coin;
    logic       chg_vld;
    logic       busy;
    logic       err;

    int checks = 0;
    int errors = 0;
    int edges  = 0;
    int base   = 0;

    typedef struct {
        logic [2:0] kind;
        logic [3:0] coin;
        logic [7:0] credit;
        int         at;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    localparam logic [2:0] K_TICKET = 3'b100;
    localparam logic [2:0] K_COIN   = 3'b010;
    localparam logic [2:0] K_ERR    = 3'b001;

    coin_credit_ctrl #(.MAX_CREDIT(8'd20)) dut (
        .clk       (clk),
        .rst       (rst),
        .fare      (fare),
        .fare_load (fare_load),
        .in_rdy    (in_rdy),
        .in_data   (in_data),
        .in_cmp    (in_cmp),
`ifdef REFUND_CANCEL_EN
        .cancel    (cancel),
`endif
        .credit    (credit),
        .ticket    (ticket),
        .chg_coin  (chg_coin),
        .chg_vld   (chg_vld),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, want, edges);
        end
    endtask

    // Monitor: any ticket/change/err output must match the next expected event.
    always @(negedge clk) begin
        if (ticket || chg_vld || err) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {20'd0, ticket, chg_vld, err, chg_coin, credit}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_kind", {29'd0, ticket, chg_vld, err}, {29'd0, mon_e.kind});
                chk("out_chg_coin", {28'd0, chg_coin}, {28'd0, mon_e.coin});
                chk("out_credit", {24'd0, credit}, {24'd0, mon_e.credit});
                chk("out_edge", edges, mon_e.at);
            end
        end
    end

    task automatic expect_ev(input logic [2:0] k, input logic [3:0] c, input logic [7:0] cr, input int off);
        ev_t e;
        e.kind   = k;
        e.coin   = c;
        e.credit = cr;
        e.at     = base + off;
        exp_q.push_back(e);
    endtask

    // Aligns to a negedge; the next posedge is edge number 'base'.
    task automatic begin_op();
        @(negedge clk);
        base = edges + 1;
    endtask

    // One coin transfer starting at the current negedge.
    task automatic xfer(input logic [7:0] v, input logic cmp, input logic extra_rdy,
                        input logic ld, input logic [7:0] ldv);
        in_rdy    = 1'b1;
        fare_load = ld;
        fare      = ldv;
        @(negedge clk);
        chk("busy_during_xfer", {31'd0, busy}, 32'd1);
        in_rdy    = extra_rdy;
        fare_load = 1'b0;
        fare      = 8'd0;
        in_data   = v;
        @(negedge clk);
        in_rdy    = 1'b0;
        in_data   = 8'd0;
        in_cmp    = cmp;
        @(negedge clk);
        in_cmp    = 1'b0;
    endtask

    task automatic wait_edge(input int n);
        int guard = 0;
        while ((edges < n) && (guard < 200)) begin
            @(negedge clk);
            guard++;
        end
        if (edges != n) chk("wait_bound", edges, n);
    endtask

    task automatic settle_check(input string name, input logic [7:0] exp_credit);
        repeat (6) @(negedge clk);
        chk(name, {24'd0, credit}, {24'd0, exp_credit});
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic load_fare(input logic [7:0] f);
        @(negedge clk);
        fare      = f;
        fare_load = 1'b1;
        @(negedge clk);
        fare      = 8'd0;
        fare_load = 1'b0;
    endtask

    task automatic coin(input logic [7:0] v, input logic [7:0] exp_credit);
        begin_op();
        xfer(v, 1'b1, 1'b0, 1'b0, 8'd0);
        settle_check("credit_after_coin", exp_credit);
    endtask

    initial begin
        rst       = 1'b1;
        fare      = 8'd0;
        fare_load = 1'b0;
        in_rdy    = 1'b0;
        in_data   = 8'd0;
        in_cmp    = 1'b0;
`ifdef REFUND_CANCEL_EN
        cancel    = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset_outputs", {16'd0, credit, ticket, chg_coin, chg_vld, busy, err}, 32'd0);
        rst = 1'b0;

        // Fare 15: coin 10 with simultaneous fare_load (in_rdy wins), then coin 10 sells.
        load_fare(8'd15);
        begin_op();
        xfer(8'd10, 1'b1, 1'b0, 1'b1, 8'd3);
        settle_check("credit_10", 8'd10);
        begin_op();
        expect_ev(K_TICKET, 4'b0000, 8'd20, 3);
        expect_ev(K_COIN,   4'b0100, 8'd0,  4);
        xfer(8'd10, 1'b1, 1'b0, 1'b0, 8'd0);
        settle_check("credit_after_sale15", 8'd0);

        // Fare 7: coin 10 -> ticket, change 2 then 1, busy drops afterwards.
        load_fare(8'd7);
        begin_op();
        expect_ev(K_TICKET, 4'b0000, 8'd10, 3);
        expect_ev(K_COIN,   4'b0010, 8'd0,  4);
        expect_ev(K_COIN,   4'b0001, 8'd0,  5);
        xfer(8'd10, 1'b1, 1'b0, 1'b0, 8'd0);
        wait_edge(base + 5);
        chk("busy_last_coin", {31'd0, busy}, 32'd1);
        wait_edge(base + 6);
        chk("busy_drop", {31'd0, busy}, 32'd0);

        // Coin 5, ignored fare load, illegal coin, missing in_cmp, then exact fare.
        coin(8'd5, 8'd5);
        load_fare(8'd1);
        begin_op();
        expect_ev(K_ERR, 4'b0000, 8'd5, 3);
        xfer(8'd3, 1'b1, 1'b0, 1'b0, 8'd0);
        settle_check("credit_after_bad_coin", 8'd5);
        begin_op();
        expect_ev(K_ERR, 4'b0000, 8'd5, 2);
        xfer(8'd10, 1'b0, 1'b0, 1'b0, 8'd0);
        settle_check("credit_after_no_cmp", 8'd5);
        coin(8'd1, 8'd6);
        begin_op();
        expect_ev(K_TICKET, 4'b0000, 8'd7, 3);
        xfer(8'd1, 1'b1, 1'b0, 1'b0, 8'd0);
        settle_check("credit_after_exact_fare", 8'd0);

        // Fare 0: accumulate to the ceiling, in_rdy while busy, then overflow refund.
        load_fare(8'd0);
        begin_op();
        expect_ev(K_ERR, 4'b0000, 8'd0, 1);
        xfer(8'd10, 1'b1, 1'b1, 1'b0, 8'd0);
        settle_check("credit_after_busy_rdy", 8'd10);
        coin(8'd10, 8'd20);
        begin_op();
        expect_ev(K_ERR,  4'b0000, 8'd20, 3);
        expect_ev(K_COIN, 4'b0100, 8'd20, 4);
        xfer(8'd5, 1'b1, 1'b0, 1'b0, 8'd0);
        settle_check("credit_after_overflow", 8'd20);

        // Reset mid-change: fare 1, coin 10 -> change 5, 2, (2 lost to rst).
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        load_fare(8'd1);
        begin_op();
        expect_ev(K_TICKET, 4'b0000, 8'd10, 3);
        expect_ev(K_COIN,   4'b0100, 8'd0,  4);
        expect_ev(K_COIN,   4'b0010, 8'd0,  5);
        xfer(8'd10, 1'b1, 1'b0, 1'b0, 8'd0);
        wait_edge(base + 5);
        rst = 1'b1;
        wait_edge(base + 6);
        chk("rst_mid_change", {16'd0, credit, ticket, chg_coin, chg_vld, busy, err}, 32'd0);
        rst = 1'b0;
        settle_check("credit_after_rst", 8'd0);

`ifdef REFUND_CANCEL_EN
        // Cancel refunds credit 8 as 5, 2, 1.
        coin(8'd5, 8'd5);
        coin(8'd2, 8'd7);
        coin(8'd1, 8'd8);
        begin_op();
        cancel = 1'b1;
        expect_ev(K_COIN, 4'b0100, 8'd0, 1);
        expect_ev(K_COIN, 4'b0010, 8'd0, 2);
        expect_ev(K_COIN, 4'b0001, 8'd0, 3);
        @(negedge clk);
        cancel = 1'b0;
        wait_edge(base + 4);
        chk("busy_after_cancel", {31'd0, busy}, 32'd0);
        // Cancel together with in_rdy: refund wins, transfer flagged.
        coin(8'd2, 8'd2);
        begin_op();
        cancel = 1'b1;
        in_rdy = 1'b1;
        expect_ev(K_ERR,  4'b0000, 8'd0, 0);
        expect_ev(K_COIN, 4'b0010, 8'd0, 1);
        @(negedge clk);
        cancel = 1'b0;
        in_rdy = 1'b0;
        settle_check("credit_after_cancel_rdy", 8'd0);
`endif

        repeat (4) @(negedge clk);
        chk("events_outstanding", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
